// File: rtl/wisc_fetch_unit.sv
// WISC instruction-fetch front end: PC, single-outstanding imem requests, prefetch queue,
// branch resolve/redirect and HLT freeze. Optional perf counters under WISC_FETCH_PERF_EN.
module wisc_fetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dec_valid,
    output logic [DATA_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              dec_ready,
    input  logic              br_valid,
    input  logic              br_reg,
    input  logic [2:0]        br_cond,
    input  logic [8:0]        br_imm,
    input  logic [ADDR_W-1:0] br_rs_data,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [2:0]        flags,
    output logic              br_taken,
    output logic              hlt,
    output logic [ADDR_W-1:0] pc
`ifdef WISC_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

    state_t            state;
    logic              outstanding;
    logic              discard;
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    logic              cond_true;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;
    logic              accept;
    logic              enq;
    logic              deq;
    logic              fetch_go;
    logic              head_hlt;
    logic              rsp_hlt;

    assign dec_inst = inst_q[rd_ptr];
    assign dec_pc   = pc_q[rd_ptr];

    // Branch resolution and per-cycle queue/fetch decisions
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000: cond_true = !flags[2];
            3'b001: cond_true = flags[2];
            3'b010: cond_true = !flags[2] && !flags[0];
            3'b011: cond_true = flags[0];
            3'b100: cond_true = flags[2] || !flags[0];
            3'b101: cond_true = flags[0] || flags[2];
            3'b110: cond_true = flags[1];
            default: cond_true = 1'b1;
        endcase
        br_off    = ADDR_W'(signed'(br_imm));
        br_target = br_reg ? br_rs_data : br_pc + ADDR_W'(2) + (br_off << 1);
        br_taken  = br_valid && cond_true && (state != HALTED);
        accept    = imem_valid && outstanding;
        enq       = accept && !discard && !br_taken;
        deq       = dec_valid && dec_ready;
        // The in-flight word already owns a slot, so only issue with nothing outstanding
        fetch_go  = (state == RUN) && !outstanding && (count < CNT_W'(DEPTH)) && !br_taken;
        head_hlt  = dec_inst[DATA_W-1 -: 4] == 4'hF;
        rsp_hlt   = imem_rdata[DATA_W-1 -: 4] == 4'hF;
        count_nxt = count + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= ADDR_W'(RESET_PC);
            imem_req    <= 1'b0;
            imem_addr   <= ADDR_W'(RESET_PC);
            outstanding <= 1'b0;
            discard     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            dec_valid   <= 1'b0;
            hlt         <= 1'b0;
        end else begin
            imem_req <= fetch_go;
            if (fetch_go) begin
                imem_addr   <= pc;
                pc          <= pc + ADDR_W'(2);
                outstanding <= 1'b1;
            end
            if (accept) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            if (br_taken) begin
                // Redirect overrides any same-cycle enqueue/dequeue; HLT in flight was speculative
                pc        <= br_target;
                state     <= RUN;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                dec_valid <= 1'b0;
                if (outstanding && !imem_valid) begin
                    discard <= 1'b1;
                end
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    if (rsp_hlt) begin
                        state <= HALT_PEND;
                    end
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    if (state == HALT_PEND && head_hlt) begin
                        state <= HALTED;
                        hlt   <= 1'b1;
                    end
                end
                count     <= count_nxt;
                dec_valid <= count_nxt != '0;
            end
        end
    end

    // Queue payload storage; occupancy is tracked by the pointers above
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= imem_addr;
        end
    end

`ifdef WISC_FETCH_PERF_EN
    logic [31:0] flush_n;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Dropped entries on redirect plus any response thrown away this cycle
    always_comb begin
        flush_n = (br_taken ? 32'(count) : 32'd0) + 32'(accept && (discard || br_taken));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= sat_add(perf_fetched, 32'(enq));
            perf_flushed <= sat_add(perf_flushed, flush_n);
            perf_stall   <= sat_add(perf_stall, 32'(dec_ready && !dec_valid));
        end
    end
`endif

endmodule

// File: tb/tb_wisc_fetch_unit.sv
// Self-checking bench for wisc_fetch_unit: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_wisc_fetch_unit;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [DATA_W-1:0] imem_rdata;
    logic              dec_valid;
    logic [DATA_W-1:0] dec_inst;
    logic [ADDR_W-1:0] dec_pc;
    logic              dec_ready;
    logic              br_valid;
    logic              br_reg;
    logic [2:0]        br_cond;
    logic [8:0]        br_imm;
    logic [ADDR_W-1:0] br_rs_data;
    logic [ADDR_W-1:0] br_pc;
    logic [2:0]        flags;
    logic              br_taken;
    logic              hlt;
    logic [ADDR_W-1:0] pc;
`ifdef WISC_FETCH_PERF_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_flushed;
    logic [31:0]       perf_stall;
`endif

    always #5 clk = ~clk;

    wisc_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready),
        .br_valid(br_valid), .br_reg(br_reg), .br_cond(br_cond), .br_imm(br_imm),
        .br_rs_data(br_rs_data), .br_pc(br_pc), .flags(flags),
        .br_taken(br_taken), .hlt(hlt), .pc(pc)
`ifdef WISC_FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [256];

    // Reference model state
    ent_t        m_q [$];
    logic [15:0] m_pc;
    logic [15:0] m_req_addr;
    bit          m_out, m_disc, m_pend, m_halted, exp_req;
    logic [15:0] req_log [$];

    // Memory responder
    bit          r_busy = 1'b0;
    int          r_timer = 0;
    logic [15:0] r_addr;

    // Stimulus knobs
    int          lat_min = 1, lat_max = 1, ready_pct = 100, br_pct = 0;
    bit          f_br = 1'b0;
    logic        f_reg;
    logic [2:0]  f_cond, f_flags;
    logic [8:0]  f_imm;
    logic [15:0] f_rs, f_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_mem(input logic [15:0] a);
        return mem[a[8:1]];
    endfunction

    function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] model_target(input logic r, input logic [8:0] imm,
                                                 input logic [15:0] rs, input logic [15:0] bpc);
        int off;
        off = int'(imm);
        if (off >= 256) off -= 512;
        if (r) return rs;
        return 16'(int'(bpc) + 2 + 2 * off);
    endfunction

    task automatic fill_mem(input int hlt_pct);
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (int'($urandom_range(99)) < hlt_pct) w[15:12] = 4'hF;
            else w[15:12] = 4'($urandom_range(14));
            mem[i] = w;
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the next edge
    task automatic model_cycle();
        bit          taken, accept;
        logic [15:0] tgt;
        ent_t        e;
        taken = br_valid && !m_halted && cond_ok(br_cond, flags);
        tgt   = model_target(br_reg, br_imm, br_rs_data, br_pc);
        check("br_taken", 32'(br_taken), 32'(taken));
        check("hlt", 32'(hlt), 32'(m_halted));
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req) begin
            check("imem_addr", 32'(imem_addr), 32'(m_pc));
            req_log.push_back(imem_addr);
            m_req_addr = m_pc;
            m_pc       = m_pc + 16'd2;
            m_out      = 1'b1;
            r_busy     = 1'b1;
            r_addr     = imem_addr;
            r_timer    = int'($urandom_range(lat_max, lat_min));
        end
        check("pc", 32'(pc), 32'(m_pc));
        check("dec_valid", 32'(dec_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("dec_pc", 32'(dec_pc), 32'(m_q[0].pc));
            check("dec_inst", 32'(dec_inst), 32'(m_q[0].inst));
        end
        accept  = imem_valid && m_out;
        exp_req = !m_pend && !m_halted && !m_out && (m_q.size() < DEPTH) && !taken;
        if (taken) begin
            m_q.delete();
            m_pc   = tgt;
            m_pend = 1'b0;
            if (accept) begin
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (m_out) begin
                m_disc = 1'b1;
            end
        end else begin
            if (dec_ready && m_q.size() != 0) begin
                e = m_q.pop_front();
                if (m_pend && e.inst[15:12] == 4'hF) begin
                    m_pend   = 1'b0;
                    m_halted = 1'b1;
                end
            end
            if (accept) begin
                m_out = 1'b0;
                if (!m_disc) begin
                    m_q.push_back('{pc: m_req_addr, inst: imem_rdata});
                    if (imem_rdata[15:12] == 4'hF) m_pend = 1'b1;
                end
                m_disc = 1'b0;
            end
        end
    endtask

    task automatic step();
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        if (r_busy) begin
            r_timer--;
            if (r_timer <= 0) begin
                imem_valid = 1'b1;
                imem_rdata = rd_mem(r_addr);
                r_busy     = 1'b0;
            end
        end
        dec_ready  = int'($urandom_range(99)) < ready_pct;
        br_reg     = 1'($urandom);
        br_cond    = 3'($urandom);
        br_imm     = 9'($urandom);
        br_rs_data = 16'($urandom);
        br_pc      = 16'($urandom);
        flags      = 3'($urandom);
        br_valid   = int'($urandom_range(99)) < br_pct;
        if (f_br) begin
            br_valid   = 1'b1;
            br_reg     = f_reg;
            br_cond    = f_cond;
            br_imm     = f_imm;
            br_rs_data = f_rs;
            br_pc      = f_pc;
            flags      = f_flags;
            f_br       = 1'b0;
        end
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic force_br(input logic r, input logic [2:0] c, input logic [2:0] f,
                            input logic [8:0] imm, input logic [15:0] rs, input logic [15:0] bpc);
        f_br = 1'b1; f_reg = r; f_cond = c; f_flags = f; f_imm = imm; f_rs = rs; f_pc = bpc;
    endtask

    function automatic bit cond_met(input int mode);
        case (mode)
            0: return m_out;
            1: return m_pend;
            2: return m_q.size() == 3 && m_out;
            default: return !m_out;
        endcase
    endfunction

    task automatic wait_for(input int mode, input int lim, input string tag);
        int n = 0;
        while (!cond_met(mode) && n < lim) begin
            step();
            n++;
        end
        check(tag, 32'(cond_met(mode)), 32'd1);
    endtask

    // Asynchronous reset in mid-cycle; a pending memory response is delivered right after release
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_hlt", 32'(hlt), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        m_q.delete();
        m_pc = 16'd0; m_out = 1'b0; m_disc = 1'b0; m_pend = 1'b0; m_halted = 1'b0; exp_req = 1'b0;
        br_valid = 1'b0; imem_valid = 1'b0; dec_ready = 1'b0;
        if (r_busy) r_timer = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
        br_valid = 1'b0; br_reg = 1'b0; br_cond = '0; br_imm = '0;
        br_rs_data = '0; br_pc = '0; flags = '0;

        // Four ADDs, 1-cycle memory, decode always ready
        fill_mem(0);
        for (int i = 0; i < 4; i++) mem[i] = {4'h0, 12'($urandom)};
        do_reset();
        req_log.delete();
        run(15);
        check("t1_nreq", 32'(req_log.size()), 32'd5);

        // Decode stalled: queue fills to DEPTH requests, then drains in order
        do_reset();
        ready_pct = 0;
        req_log.delete();
        run(16);
        check("t2_nreq", 32'(req_log.size()), 32'd4);
        ready_pct = 100;
        run(20);

        // B EQ taken, target 0x0010 + 2 - 4
        do_reset();
        run(6);
        req_log.delete();
        force_br(1'b0, 3'b001, 3'b100, 9'h1FE, 16'h0, 16'h0010);
        run(8);
        check("t3_nreq", 32'(req_log.size() != 0), 32'd1);
        if (req_log.size() != 0) check("t3_target", 32'(req_log[0]), 32'h000E);

        // BR NE with Z=1 not taken, then BR always while a slow fetch is in flight
        force_br(1'b1, 3'b000, 3'b100, 9'h0, 16'h4444, 16'h0);
        step();
        wait_for(3, 20, "t4_idle");
        lat_min = 3; lat_max = 3;
        wait_for(0, 20, "t4_out");
        req_log.delete();
        force_br(1'b1, 3'b111, 3'b000, 9'h0, 16'h1234, 16'h0);
        run(12);
        check("t4_nreq", 32'(req_log.size() != 0), 32'd1);
        if (req_log.size() != 0) check("t4_target", 32'(req_log[0]), 32'h1234);
        lat_min = 1; lat_max = 1;

        // HLT at 0x0008 freezes fetch; branches in HALTED are ignored
        fill_mem(0);
        mem[4] = 16'hF000;
        do_reset();
        req_log.delete();
        run(40);
        found = 1'b0;
        foreach (req_log[i]) if (req_log[i] == 16'h000A) found = 1'b1;
        check("t5_no_0a", 32'(found), 32'd0);
        check("t5_nreq", 32'(req_log.size()), 32'd5);
        check("t5_hlt", 32'(hlt), 32'd1);
        br_pct = 50;
        run(10);
        br_pct = 0;
        check("t5_pc", 32'(pc), 32'h000A);

        // Taken branch while HLT waits in the queue resumes fetch at the target
        fill_mem(0);
        mem[2] = 16'hF000;
        do_reset();
        ready_pct = 0;
        wait_for(1, 50, "t6_pend");
        req_log.delete();
        force_br(1'b0, 3'b111, 3'b000, 9'h010, 16'h0, 16'h0000);
        step();
        ready_pct = 100;
        run(15);
        check("t6_nreq", 32'(req_log.size() != 0), 32'd1);
        if (req_log.size() != 0) check("t6_target", 32'(req_log[0]), 32'h0022);

        // Reset with a slow request in flight and a nearly full queue
        fill_mem(0);
        do_reset();
        ready_pct = 0; lat_min = 6; lat_max = 6;
        wait_for(2, 80, "t7_full");
        do_reset();
        ready_pct = 100; lat_min = 1; lat_max = 1;
        req_log.delete();
        run(10);
        check("t7_nreq", 32'(req_log.size() != 0), 32'd1);
        if (req_log.size() != 0) check("t7_restart", 32'(req_log[0]), 32'h0000);

        // Randomized traffic with sporadic HLTs and branches
        for (int r = 0; r < 6; r++) begin
            fill_mem(3);
            do_reset();
            lat_min = 1; lat_max = 4; ready_pct = 70; br_pct = 8;
            run(400);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wisc_fetch_unit.md
Name: wisc_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the WISC CPU core. It replaces the single-cycle PC register and PC_control path.
- Holds the PC and issues requests to instruction memory, which may return data after a variable latency. Fetched words are buffered in a prefetch queue and handed to decode through a valid/ready handshake.
- Resolves B/BR branch conditions against the {Z,V,N} flags and redirects fetch when a branch is taken.
- Detects HLT (opcode 4'hF), stops fetch and freezes the machine.

Parameters:
ADDR_W, 16, PC / instruction-address width in bits
DATA_W, 16, instruction width; opcode is bits [DATA_W-1:DATA_W-4]
DEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
imem_req  out  1  one-cycle fetch request pulse
imem_addr  out  ADDR_W  fetch address; valid while imem_req=1
imem_valid  in  1  response strobe for the single outstanding request
imem_rdata  in  DATA_W  fetched instruction; valid while imem_valid=1
dec_valid  out  1  queue head valid
dec_inst  out  DATA_W  queue-head instruction
dec_pc  out  ADDR_W  address of queue-head instruction
dec_ready  in  1  decode accepts the head this cycle
br_valid  in  1  branch resolve request from decode/execute
br_reg  in  1  1 = BR (target = rs), 0 = B (target = PC-relative)
br_cond  in  3  condition code ccc
br_imm  in  9  signed word offset for B
br_rs_data  in  ADDR_W  rs register value for BR
br_pc  in  ADDR_W  address of the branch instruction
flags  in  3  {Z,V,N}
br_taken  out  1  combinational: br_valid and condition true
hlt  out  1  registered halt indication
pc  out  ADDR_W  current fetch PC

Behaviour:
- Interface: one clock domain, clk; reset rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, queue empty, no request outstanding, state RUN, hlt=0, imem_req=0, dec_valid=0.
- States:
  - RUN: fetch is active.
  - HALT_PEND: an HLT word has been fetched but not yet consumed by decode.
  - HALTED: machine frozen.
- Fetch in RUN: assert imem_req with imem_addr=pc when no request is outstanding and the queue has a free slot. The free-slot check counts the in-flight entry, so the queue never overflows. pc advances by 2 in the same cycle as imem_req.
- Response: imem_valid with no request outstanding is ignored. Otherwise the word is enqueued with its address; latency is at least 1 cycle after imem_req.
- If the enqueued word's opcode is 4'hF: enqueue it, go to HALT_PEND, and issue no further requests.
- Dequeue: head pops when dec_valid && dec_ready. dec_* are driven from queue registers (no comb path from imem_rdata).
- Simultaneous enqueue and dequeue when the queue is full is legal; occupancy stays the same.
- Condition codes (Z,V,N):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 && N=0
  - 011 LT: N=1
  - 100 GE: Z=1 || (Z=0 && N=0)
  - 101 LE: N=1 || Z=1
  - 110 OV: V=1
  - 111 always
- Branch target:
  - B: br_pc + 2 + (sext(br_imm) << 1), modulo 2^ADDR_W (wraps silently).
  - BR: br_rs_data.
- Taken branch, next edge:
  - flush the queue; pc = target.
  - If a request is outstanding, mark it discard: its response is dropped.
  - State returns to RUN, including from HALT_PEND (the HLT was speculative).
  - The redirect wins over a same-cycle enqueue or dequeue.
- First fetch after redirect:
  - issued the cycle after the redirect if nothing is outstanding;
  - otherwise, the cycle after the discarded response arrives.
- Not-taken branch: no effect.
- br_valid in HALTED is ignored.
- HALT_PEND -> HALTED when the HLT entry is dequeued. hlt=1 from the next edge onward; pc frozen.
- HALTED exits only on rst.
- rst mid-operation (outstanding request, full queue, or HALTED): all state is cleared immediately. A later imem_valid is ignored because nothing is outstanding.

Optional Feature:
- Macro: WISC_FETCH_PERF_EN.
- Defined: adds three 32-bit saturating counters, cleared by rst:
  - perf_fetched: words enqueued
  - perf_flushed: entries dropped plus responses discarded by redirects
  - perf_stall: cycles with dec_ready=1 and dec_valid=0
  - Exposed as extra output ports.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, imem 1-cycle latency, dec_ready=1, program of four ADDs at 0x0000 -> imem_addr 0x0000, 0x0002, 0x0004, 0x0006; dec_pc in the same order; hlt=0.
- dec_ready=0 for 10 cycles -> exactly 4 requests issued (DEPTH=4), dec_valid=1 holding PC 0x0000; release -> entries drain in order with no loss or duplicate.
- B with br_cond=001, flags Z=1, br_pc=0x0010, br_imm=9'h1FE (-2) -> br_taken=1, next imem_addr=0x000E, queue empty the next cycle.
- BR with br_cond=000, Z=1 -> br_taken=0, fetch continues sequentially. Then BR with ccc=111, br_rs_data=0x1234, issued while a 3-cycle-latency fetch is outstanding -> stale response dropped, next imem_addr=0x1234.
- HLT word at 0x0008 -> no request to 0x000A; hlt=1 the cycle after decode accepts the HLT; pc stays 0x000A forever. A taken branch asserted in HALT_PEND before decode accepts the HLT -> return to RUN at the target.
- Assert rst mid-run with an outstanding request and a full queue -> outputs return to reset values asynchronously; the late imem_valid is ignored; fetch restarts at RESET_PC.
